// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end for a shared binary/Gray converter.
// One-entry registered response slot, drained through a valid/ready port.
module gray_conv_arbiter #(
    parameter int BW_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic               i_req0_mode,
    input  logic [BW_DATA-1:0] i_req0_data,
    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic               i_req1_mode,
    input  logic [BW_DATA-1:0] i_req1_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_data,
    output logic               o_rsp_id,
    output logic               o_rsp_mode,
    output logic               o_busy
);

    logic               last_grant;
    logic               can_accept;
    logic               grant0;
    logic               grant1;
    logic               take0;
    logic               take1;
    logic               sel_mode;
    logic [BW_DATA-1:0] sel_data;
    logic [BW_DATA-1:0] conv_data;

    function automatic logic [BW_DATA-1:0] bin_to_gray(
        input logic [BW_DATA-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [BW_DATA-1:0] gray_to_bin(
        input logic [BW_DATA-1:0] g
    );
        logic [BW_DATA-1:0] b;
        b[BW_DATA-1] = g[BW_DATA-1];
        for (int i = BW_DATA - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Round-robin grant; on contention the requester not served last wins.
    always_comb begin
        can_accept   = !o_rsp_valid | i_rsp_ready;
        grant0       = i_req0_valid & (!i_req1_valid | last_grant);
        grant1       = i_req1_valid & (!i_req0_valid | !last_grant);
        o_req0_ready = !i_rst & can_accept & grant0;
        o_req1_ready = !i_rst & can_accept & grant1;
        take0        = o_req0_ready & i_req0_valid;
        take1        = o_req1_ready & i_req1_valid;
        o_busy       = o_rsp_valid | i_req0_valid | i_req1_valid;
    end

    // Mux the granted operand into the single shared converter.
    always_comb begin
        sel_mode  = take1 ? i_req1_mode : i_req0_mode;
        sel_data  = take1 ? i_req1_data : i_req0_data;
        conv_data = sel_mode ? gray_to_bin(sel_data)
                             : bin_to_gray(sel_data);
    end

    // Response slot: load on accept, clear on drain, hold under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= 1'b0;
            o_rsp_mode  <= 1'b0;
            last_grant  <= 1'b1;
        end else if (take0 | take1) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= conv_data;
            o_rsp_id    <= take1;
            o_rsp_mode  <= sel_mode;
            last_grant  <= take1;
        end else if (o_rsp_valid & i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter.
// Inputs and samples change on the falling edge; the DUT updates on rising.
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_mode;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       req1_mode;
    logic [7:0] req1_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       rsp_mode;
    logic       busy;

    int errors = 0;
    int checks = 0;

    gray_conv_arbiter #(.BW_DATA(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_mode  (req0_mode),
        .i_req0_data  (req0_data),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_mode  (req1_mode),
        .i_req1_data  (req1_data),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .o_rsp_mode   (rsp_mode),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic m0, input logic [7:0] d0,
                         input logic v1, input logic m1, input logic [7:0] d1);
        req0_valid = v0;
        req0_mode  = m0;
        req0_data  = d0;
        req1_valid = v1;
        req1_mode  = m1;
        req1_data  = d1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 8'hAA);
        step();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== 11'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h id=%b m=%b want all 0",
                     rsp_valid, rsp_data, rsp_id, rsp_mode);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_req0();
        drive(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single0_ready: got r0=%b r1=%b busy=%b want 1 0 1",
                     req0_ready, req1_ready, busy);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single0_rsp: got v=%b d=%h id=%b m=%b want 1 07 0 0",
                     rsp_valid, rsp_data, rsp_id, rsp_mode);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h07) begin
            errors++;
            $display("FAIL single0_drain: got v=%b d=%h want 0 07", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_single_req1();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80);
        step();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 8'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single1_g2b: got v=%b d=%h id=%b m=%b want 1 ff 1 1",
                     rsp_valid, rsp_data, rsp_id, rsp_mode);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 8'h80, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single1_b2g: got v=%b d=%h id=%b m=%b want 1 80 1 0",
                     rsp_valid, rsp_data, rsp_id, rsp_mode);
        end
        step();
    endtask

    task automatic test_contention();
        logic       exp_id;
        logic [7:0] exp_d;
        drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h03);
        for (int i = 0; i < 6; i++) begin
            step();
            exp_id = i[0];
            exp_d  = exp_id ? 8'h02 : 8'h01;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_d) begin
                errors++;
                $display("FAIL contention_%0d: got v=%b id=%b d=%h want 1 %b %h",
                         i, rsp_valid, rsp_id, rsp_data, exp_id, exp_d);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h03);
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_%0d: got %b%b want 00", i, req0_ready, req1_ready);
            end
            step();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'h01, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h id=%b want 1 01 0",
                         i, rsp_valid, rsp_data, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b%b want 01", req0_ready, req1_ready);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'h02, 1'b1}) begin
            errors++;
            $display("FAIL bp_nobubble: got v=%b d=%h id=%b want 1 02 1",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pending: got v=%b id=%b want 1 0", rsp_valid, rsp_id);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_valid: got %b want 0", rsp_valid);
        end
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 8'h08);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_prio: got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (rsp_id !== 1'b0 || rsp_data !== 8'h06) begin
            errors++;
            $display("FAIL rstmid_rsp: got id=%b d=%h want 0 06", rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_exhaustive();
        logic [7:0] g;
        logic [7:0] prev_g;
        logic [7:0] b;
        logic [7:0] exp_g;
        int         bad_rt = 0;
        int         bad_ham = 0;
        int         bad_g = 0;
        rsp_ready = 1'b1;
        prev_g    = 8'h00;
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            exp_g = b ^ {1'b0, b[7:1]};
            drive(1'b1, 1'b0, b, 1'b0, 1'b0, 8'h00);
            step();
            g = rsp_data;
            if (g !== exp_g) bad_g++;
            if (v > 0 && $countones(g ^ prev_g) != 1) bad_ham++;
            prev_g = g;
            drive(1'b1, 1'b1, g, 1'b0, 1'b0, 8'h00);
            step();
            if (rsp_data !== b || rsp_mode !== 1'b1) bad_rt++;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        checks++;
        if (bad_g != 0) begin
            errors++;
            $display("FAIL sweep_gray: got %0d wrong codes want 0", bad_g);
        end
        checks++;
        if (bad_ham != 0) begin
            errors++;
            $display("FAIL sweep_hamming: got %0d non-unit steps want 0", bad_ham);
        end
        checks++;
        if (bad_rt != 0) begin
            errors++;
            $display("FAIL sweep_roundtrip: got %0d bad returns want 0", bad_rt);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_idle: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_req0();
        test_single_req1();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shares a single registered binary/Gray conversion stage (bin_to_gray and gray_to_bin, BW_DATA wide) between two requesters. Each requester issues a valid/ready request carrying a data word and a direction bit. A round-robin arbiter grants one request per cycle into a one-entry output register, which is drained through a valid/ready response port tagged with the requester ID. The block sits between the pointer/counter logic that needs code conversion and the single shared converter instance.

## Interface
- BW_DATA, 8, data width of requests and responses (≥1)
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has a request
- o_req0_ready  out  1  requester 0 request accepted this cycle
- i_req0_mode  in  1  0 = binary→Gray, 1 = Gray→binary
- i_req0_data  in  BW_DATA  operand
- i_req1_valid / o_req1_ready / i_req1_mode / i_req1_data  same as requester 0, for requester 1
- o_rsp_valid  out  1  response register holds a result
- i_rsp_ready  in  1  consumer accepts the response
- o_rsp_data  out  BW_DATA  converted result
- o_rsp_id  out  1  requester that issued the result (0/1)
- o_rsp_mode  out  1  mode of the request that produced the result
- o_busy  out  1  o_rsp_valid | i_req0_valid | i_req1_valid

## Operation
- can_accept = !o_rsp_valid | i_rsp_ready.
- Arbitration (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - None valid: no grant.
- o_reqN_ready = can_accept & grant_N. At most one ready is high per cycle. Ready may depend combinationally on valid. Requesters must hold valid, mode and data stable until ready is high.
- Handshake on requester N (valid & ready) at an edge:
  - o_rsp_data ← mode ? gray_to_bin(data) : bin_to_gray(data)
  - o_rsp_id ← N, o_rsp_mode ← mode, o_rsp_valid ← 1, last_grant ← N
- Response handshake (o_rsp_valid & i_rsp_ready) with no new request: o_rsp_valid ← 0. o_rsp_data, o_rsp_id and o_rsp_mode hold their last values.
- Response handshake and a new request in the same cycle: the new result is loaded and o_rsp_valid stays 1. No bubble, full throughput.
- o_rsp_valid & !i_rsp_ready: the response register and last_grant hold. Both readies are 0.
- last_grant changes only on an accepted request. A requester that is refused because of backpressure keeps its priority.
- Conversion:
  - g[i] = b[i] ^ b[i+1]; g[MSB] = b[MSB]
  - b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]
  - Both directions are pure bitwise operations: no carries and no width growth.

## Timing
- Reset (i_rst high at an edge) sets:
  - o_rsp_valid = 0, o_rsp_data = 0, o_rsp_id = 0, o_rsp_mode = 0, last_grant = 1 (requester 0 wins the first contention)
- While i_rst is high, o_req0_ready and o_req1_ready are forced to 0.
- Reset asserted while a response is pending discards it: o_rsp_valid = 0 after the edge. No request is accepted during the reset cycle.
- Latency: a request accepted at edge k makes its result visible on o_rsp_* after edge k, i.e. one cycle.
- Throughput: one result per cycle while i_rsp_ready = 1.
- Fairness: under continuous contention with i_rsp_ready = 1, grants alternate 0,1,0,1,… Each requester waits at most 1 cycle for a grant, plus any backpressure cycles.
- Every output comes directly from a register, except o_reqN_ready and o_busy, which are combinational.

## Test plan
- After reset, only requester 0 valid, mode 0, data 8'h05, i_rsp_ready = 1:
  - o_req0_ready = 1
  - next cycle: o_rsp_valid = 1, o_rsp_data = 8'h07, o_rsp_id = 0, o_rsp_mode = 0
- Requester 1 alone, mode 1, data 8'h80: response o_rsp_data = 8'hFF, o_rsp_id = 1. Then mode 0, data 8'hFF: response 8'h80.
- Both valid every cycle (req0 data 8'h01 mode 0, req1 data 8'h03 mode 1), i_rsp_ready = 1, for 6 cycles:
  - responses alternate id 0,1,0,1,0,1, starting with 0
  - data alternates 8'h01, 8'h02
- Backpressure: response pending and i_rsp_ready = 0 for 3 cycles with both requesters valid:
  - both readies stay 0
  - o_rsp_* holds unchanged
  - on release, the response is consumed and the next grant loads in the same cycle with no bubble
- Reset mid-operation: i_rst pulsed for one cycle while o_rsp_valid = 1 and i_rsp_ready = 0:
  - o_rsp_valid = 0 after the edge
  - the next contention is granted to requester 0
- Exhaustive per mode: sweep all 256 values through requester 0 with mode 0, then feed each result back with mode 1. Every round trip must return the original value, and adjacent binary inputs must give Gray outputs at Hamming distance 1.
